// File: rtl/ehgu_blk_rev_mem_if.sv
// ehgu_blk_rev_mem_if: stream bundle for the block reverser.
//   in_valid/in_data                      : valid-only input stream
//   out_valid/out_data/out_first/out_last : valid-only reversed output stream
//   fill                                  : samples held in the current write bank
// master = producer/consumer side (testbench), slave = reverser.
interface ehgu_blk_rev_mem_if #(
    parameter int unsigned BLOCK = 16,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned FW = $clog2(BLOCK) + 1;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_first;
    logic             out_last;
    logic [FW-1:0]    fill;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_first, out_last, fill
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_first, out_last, fill
    );
endinterface

// File: rtl/ehgu_blk_rev_mem.sv
// ehgu_blk_rev_mem: memory-backed block reverser.
// Samples are written in address order into one half (bank) of a 2*BLOCK dual-port RAM.
// When a bank fills, the banks swap and the full bank is read back in descending address
// order, so each block of BLOCK samples leaves last-in first-out.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ehgu_blk_rev_mem_if.slave (in_valid/in_data in; out_valid/out_data/out_first/
//          out_last/fill out)
// Latency: the sample completing a block is on out_data two edges after it is sampled.

// Simple dual-port RAM with one-cycle registered read. Contents are not reset.
module ehgu_ram_dual_port #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     wenable,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     renable,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wenable) begin
            mem[waddr] <= wdata;
        end
        if (renable) begin
            rdata <= mem[raddr];
        end
    end
endmodule

module ehgu_blk_rev_mem #(
    parameter int unsigned BLOCK = 16,
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    ehgu_blk_rev_mem_if.slave bus
);
    localparam int unsigned CW    = $clog2(BLOCK);
    localparam int unsigned AW    = CW + 1;
    localparam int unsigned DEPTH = 2 * BLOCK;

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    // Write side
    logic [CW-1:0] wcnt_q;
    logic          wbank_q;
    logic          arm;

    // Read side
    state_e        state_q, state_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          rbank_q, rbank_d;
    logic          renable;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;

    // Tags travelling alongside the RAM read (valid when rdata is)
    logic rd_valid_q, rd_first_q, rd_last_q;

    logic [WIDTH-1:0] rdata;
    logic             out_valid_q, out_first_q, out_last_q;
    logic [WIDTH-1:0] out_data_q;

    // A block completes when the last slot of the write bank is written.
    assign arm   = bus.in_valid && (wcnt_q == CW'(BLOCK - 1));
    assign waddr = {wbank_q, wcnt_q};
    assign raddr = {rbank_q, rcnt_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q  <= '0;
            wbank_q <= 1'b0;
        end else if (bus.in_valid) begin
            wcnt_q <= wcnt_q + CW'(1);  // wraps to 0 at block end
            if (arm) begin
                wbank_q <= ~wbank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rcnt_q  <= '0;
            rbank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            rbank_q <= rbank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        renable = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StRead;
                    rbank_d = wbank_q;
                    rcnt_d  = CW'(BLOCK - 1);
                end
            end
            StRead: begin
                renable = 1'b1;
                rcnt_d  = rcnt_q - CW'(1);
                if (rcnt_q == '0) begin
                    // A fresh arm on the final read keeps the readout running gap-free.
                    if (arm) begin
                        rbank_d = wbank_q;
                        rcnt_d  = CW'(BLOCK - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    ehgu_ram_dual_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wenable (bus.in_valid),
        .waddr   (waddr),
        .wdata   (bus.in_data),
        .renable (renable),
        .raddr   (raddr),
        .rdata   (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= renable;
            rd_first_q <= renable && (rcnt_q == CW'(BLOCK - 1));
            rd_last_q  <= renable && (rcnt_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rd_valid_q;
            out_first_q <= rd_first_q;
            out_last_q  <= rd_last_q;
            if (rd_valid_q) begin
                out_data_q <= rdata;  // otherwise hold the previous sample
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.fill      = {1'b0, wcnt_q};
endmodule

// File: tb/tb_ehgu_blk_rev_mem.sv
// Testbench for ehgu_blk_rev_mem (BLOCK=4, WIDTH=8): scheduled-output reference model,
// per-cycle compare, directed literal scenarios and a randomized gapped stream.
module tb_ehgu_blk_rev_mem;
    localparam int unsigned BLOCK = 4;
    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             f;
        logic             l;
    } exp_t;

    typedef struct {
        int               e;
        logic [WIDTH-1:0] d;
        logic             f;
        logic             l;
    } cap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ehgu_blk_rev_mem_if #(.BLOCK(BLOCK), .WIDTH(WIDTH)) bus ();

    ehgu_blk_rev_mem #(.BLOCK(BLOCK), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int rst_edge = -1;
    bit started = 1'b0;
    logic [WIDTH-1:0] part [$];   // samples of the block being filled
    exp_t exp_q [int];            // expected output keyed by edge number
    cap_t cap [$];                // every DUT output beat observed
    logic [WIDTH-1:0] hold = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, want, edge_n);
        end
    endtask

    // Reference model: a completed block's samples leave reversed, starting two edges after
    // the completing sample, one per edge. Reset wipes the partial block and pending output.
    initial forever begin
        int kill [$];
        @(posedge clk);
        edge_n++;
        if (rst) begin
            rst_edge = edge_n;
            part.delete();
            kill.delete();
            foreach (exp_q[k]) if (k >= edge_n) kill.push_back(k);
            foreach (kill[i]) exp_q.delete(kill[i]);
        end else if (bus.in_valid) begin
            part.push_back(bus.in_data);
            if (part.size() == BLOCK) begin
                for (int k = 0; k < BLOCK; k++) begin
                    exp_q[edge_n + 2 + k] = '{d: part[BLOCK-1-k], f: (k == 0),
                                              l: (k == BLOCK - 1)};
                end
                part.delete();
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            if (bus.out_valid === 1'b1) begin
                cap.push_back('{e: edge_n, d: bus.out_data, f: bus.out_first,
                                l: bus.out_last});
            end
            if (exp_q.exists(edge_n)) begin
                chk("out_valid", bus.out_valid, 1);
                chk("out_data", bus.out_data, exp_q[edge_n].d);
                chk("out_first", bus.out_first, exp_q[edge_n].f);
                chk("out_last", bus.out_last, exp_q[edge_n].l);
                hold = exp_q[edge_n].d;
            end else begin
                if (edge_n == rst_edge) hold = '0;
                chk("idle_valid", bus.out_valid, 0);
                chk("idle_hold", bus.out_data, hold);
                chk("idle_first", bus.out_first, 0);
                chk("idle_last", bus.out_last, 0);
            end
            chk("fill", bus.fill, part.size());
        end
    end

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
        bus.in_valid = v;
        bus.in_data  = d;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic wait_caps(input int n, input int budget);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            step(1'b0, '0, 1'b0);
            k++;
        end
        chk("wait_caps", (cap.size() >= n), 1);
    endtask

    // Check captured beats against a literal reversed sequence of length n.
    task automatic chk_seq(input string nm, input logic [WIDTH-1:0] want [$]);
        chk({nm, "_count"}, cap.size(), want.size());
        for (int i = 0; i < want.size() && i < cap.size(); i++) begin
            chk({nm, "_data"}, cap[i].d, want[i]);
            chk({nm, "_first"}, cap[i].f, (i % BLOCK) == 0);
            chk({nm, "_last"}, cap[i].l, (i % BLOCK) == BLOCK - 1);
            chk({nm, "_gapless"}, cap[i].e, cap[0].e + i);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] want [$];
        logic [2:0] fills [7];
        logic       gv [7];
        logic [7:0] gd [7];
        int e_last;
        int errs;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        started = 1'b1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_fill", bus.fill, 0);
        step(1'b0, '0, 1'b0);

        // Continuous 1..8
        cap.delete();
        e_last = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 4) e_last = edge_n;
        end
        wait_caps(8, 20);
        idle(4);
        want = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd8, 8'd7, 8'd6, 8'd5};
        chk_seq("cont", want);
        if (cap.size() > 0) chk("cont_latency", cap[0].e, e_last + 2);

        // Gapped input with fill trace
        cap.delete();
        gv    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        gd    = '{8'h10, 8'h00, 8'h11, 8'h00, 8'h00, 8'h12, 8'h13};
        fills = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0};
        for (int i = 0; i < 7; i++) begin
            step(gv[i], gd[i], 1'b0);
            chk("gap_fill", bus.fill, fills[i]);
        end
        e_last = edge_n;
        wait_caps(4, 20);
        idle(4);
        want = '{8'h13, 8'h12, 8'h11, 8'h10};
        chk_seq("gap", want);
        if (cap.size() > 0) chk("gap_latency", cap[0].e, e_last + 2);

        // Partial block is held forever
        cap.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
        idle(50);
        chk("partial_none", cap.size(), 0);
        chk("partial_fill", bus.fill, 3);
        step(1'b0, '0, 1'b1);

        // Reset during readout after two beats
        cap.delete();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        idle(3);
        step(1'b0, '0, 1'b1);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_data", bus.out_data, 0);
        want = '{8'd4, 8'd3};
        chk_seq("midrst_pre", want);
        cap.delete();
        for (int i = 5; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        wait_caps(4, 20);
        idle(6);
        want = '{8'd8, 8'd7, 8'd6, 8'd5};
        chk_seq("midrst_post", want);

        // Reset discards a partial block
        cap.delete();
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hE1, 1'b0);
        step(1'b0, '0, 1'b1);
        for (int i = 9; i <= 12; i++) step(1'b1, 8'(i), 1'b0);
        wait_caps(4, 20);
        idle(6);
        want = '{8'd12, 8'd11, 8'd10, 8'd9};
        chk_seq("partrst", want);

        // 64 back-to-back blocks of a counter
        cap.delete();
        for (int i = 0; i < 64 * BLOCK; i++) step(1'b1, 8'(i), 1'b0);
        wait_caps(64 * BLOCK, 20);
        idle(4);
        chk("b2b_count", cap.size(), 64 * BLOCK);
        errs = 0;
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i].d !== 8'((i / BLOCK) * BLOCK + (BLOCK - 1) - (i % BLOCK))) errs++;
            if (cap[i].e != cap[0].e + i) errs++;
        end
        chk("b2b_order_errs", errs, 0);

        // Randomized gapped stream with rare resets; the per-cycle compare does the checking
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 99) == 0));
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
